// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU.
// Produces {remainder, quotient} with MIPS truncating semantics.
module div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 signed_div,
    input  logic [WIDTH-1:0]     opdata1,
    input  logic [WIDTH-1:0]     opdata2,
    input  logic                 start,
    input  logic                 annul,
    output logic [2*WIDTH-1:0]   result,
    output logic                 ready
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_BYZERO = 2'd1,
        S_ON     = 2'd2,
        S_END    = 2'd3
    } state_t;

    state_t              state, state_n;
    logic [CW-1:0]       cnt, cnt_n;
    logic [2*WIDTH:0]    work, work_n;
    logic [WIDTH-1:0]    divisor, divisor_n;
    logic                s1, s1_n, s2, s2_n;
    logic [2*WIDTH-1:0]  result_n;
    logic                ready_n;

    logic [WIDTH-1:0]    mag1_c, mag2_c;
    logic [WIDTH:0]      upper_c, diff_c;
    logic [WIDTH-1:0]    quo_c, rem_c;

    // Operand magnitudes and the trial subtraction for one iteration
    always_comb begin
        mag1_c  = (signed_div && opdata1[WIDTH-1]) ? (~opdata1 + WIDTH'(1)) : opdata1;
        mag2_c  = (signed_div && opdata2[WIDTH-1]) ? (~opdata2 + WIDTH'(1)) : opdata2;
        upper_c = work[2*WIDTH:WIDTH];
        diff_c  = upper_c - {1'b0, divisor};
        quo_c   = (s1 ^ s2) ? (~work[WIDTH-1:0] + WIDTH'(1)) : work[WIDTH-1:0];
        rem_c   = s1 ? (~work[2*WIDTH:WIDTH+1] + WIDTH'(1)) : work[2*WIDTH:WIDTH+1];
    end

    // Next-state and datapath update
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        work_n    = work;
        divisor_n = divisor;
        s1_n      = s1;
        s2_n      = s2;
        result_n  = result;
        ready_n   = ready;

        case (state)
            S_IDLE: begin
                ready_n  = 1'b0;
                result_n = '0;
                if (start && !annul) begin
                    if (opdata2 == '0) begin
                        state_n = S_BYZERO;
                    end else begin
                        state_n   = S_ON;
                        cnt_n     = '0;
                        work_n    = {WIDTH'(0), mag1_c, 1'b0};
                        divisor_n = mag2_c;
                        s1_n      = signed_div & opdata1[WIDTH-1];
                        s2_n      = signed_div & opdata2[WIDTH-1];
                    end
                end
            end
            S_BYZERO: begin
                if (annul) begin
                    state_n = S_IDLE;
                end else begin
                    state_n  = S_END;
                    result_n = '0;
                    ready_n  = 1'b1;
                end
            end
            S_ON: begin
                if (annul) begin
                    state_n  = S_IDLE;
                    ready_n  = 1'b0;
                    result_n = '0;
                end else if (cnt != CW'(WIDTH)) begin
                    // A set sign bit of the W+1-bit difference means "restore"
                    cnt_n  = cnt + CW'(1);
                    work_n = diff_c[WIDTH] ? {work[2*WIDTH-1:0], 1'b0}
                                           : {diff_c[WIDTH-1:0], work[WIDTH-1:0], 1'b1};
                end else begin
                    state_n  = S_END;
                    result_n = {rem_c, quo_c};
                    ready_n  = 1'b1;
                end
            end
            S_END: begin
                if (!start) begin
                    state_n  = S_IDLE;
                    ready_n  = 1'b0;
                    result_n = '0;
                end
            end
            default: begin
                state_n  = S_IDLE;
                ready_n  = 1'b0;
                result_n = '0;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            work    <= '0;
            divisor <= '0;
            s1      <= 1'b0;
            s2      <= 1'b0;
            result  <= '0;
            ready   <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            work    <= work_n;
            divisor <= divisor_n;
            s1      <= s1_n;
            s2      <= s2_n;
            result  <= result_n;
            ready   <= ready_n;
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: transaction-level model plus directed and random divisions.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        signed_div;
    logic [31:0] opdata1, opdata2;
    logic        start, annul;
    logic [63:0] result;
    logic        ready;

    int pass_cnt = 0;
    int tot_cnt  = 0;

    div_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .signed_div(signed_div),
        .opdata1(opdata1), .opdata2(opdata2),
        .start(start), .annul(annul),
        .result(result), .ready(ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Reference: divide magnitudes, then apply MIPS sign rules
    function automatic logic [63:0] ref_div(input logic sd, input logic [31:0] a, input logic [31:0] b);
        longint unsigned ma, mb, q, r;
        logic [31:0] qq, rr;
        if (b == 32'd0) return 64'd0;
        ma = (sd && a[31]) ? (64'h1_0000_0000 - {32'd0, a}) : {32'd0, a};
        mb = (sd && b[31]) ? (64'h1_0000_0000 - {32'd0, b}) : {32'd0, b};
        q  = ma / mb;
        r  = ma % mb;
        qq = q[31:0];
        rr = r[31:0];
        if (sd && (a[31] ^ b[31])) qq = -qq;
        if (sd && a[31]) rr = -rr;
        return {rr, qq};
    endfunction

    // Transaction-level model of the handshake and latency
    bit          mvalid = 0, m_busy = 0, m_done = 0;
    int          m_edges, m_lat;
    logic [63:0] m_val;
    logic        exp_ready = 0;
    logic [63:0] exp_result = '0;

    always @(posedge clk) begin
        if (rst) begin
            mvalid = 1; m_busy = 0; m_done = 0;
            exp_ready = 0; exp_result = '0;
        end else if (!m_busy && !m_done) begin
            if (start && !annul) begin
                m_busy  = 1;
                m_edges = 1;
                m_lat   = (opdata2 == 32'd0) ? 2 : 34;
                m_val   = ref_div(signed_div, opdata1, opdata2);
            end
        end else if (m_busy) begin
            if (annul) m_busy = 0;
            else begin
                m_edges++;
                if (m_edges == m_lat) begin
                    m_busy = 0; m_done = 1;
                    exp_ready = 1; exp_result = m_val;
                end
            end
        end else if (!start) begin
            m_done = 0; exp_ready = 0; exp_result = '0;
        end
    end

    always @(negedge clk) begin
        if (mvalid) begin
            chk("ready", {63'd0, ready}, {63'd0, exp_ready});
            chk("result", result, exp_result);
        end
    end

    // One division; optionally annulled after annul_at edges; lit checked at completion
    task automatic run(input logic sd, input logic [31:0] a, input logic [31:0] b,
                       input int hold, input int annul_at,
                       input bit has_lit, input logic [63:0] lit);
        int n, lat;
        @(negedge clk);
        signed_div = sd; opdata1 = a; opdata2 = b; start = 1; annul = 0;
        n = 0; lat = 0;
        while (n < 60 && lat == 0) begin
            @(posedge clk); #1; n++;
            if (ready) lat = n;
            else begin
                opdata1 = $urandom; opdata2 = $urandom; signed_div = 1'($urandom % 2);
                if (annul_at != 0 && n == annul_at) annul = 1;
                else if (annul_at != 0 && n == annul_at + 1) begin
                    annul = 0; start = 0; break;
                end
            end
        end
        if (annul_at == 0) begin
            chk("latency", 64'(lat), (b == 32'd0) ? 64'd2 : 64'd34);
            if (has_lit) chk("literal", result, lit);
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                annul = 1'($urandom % 2);
            end
            @(negedge clk); start = 0; annul = 0;
            @(negedge clk);
        end else begin
            @(negedge clk); start = 0; annul = 0;
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom % 8)
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return $urandom % 16;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int hi;
        rst = 1; signed_div = 0; opdata1 = 0; opdata2 = 0; start = 0; annul = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ready", {63'd0, ready}, 64'd0);
        chk("reset_result", result, 64'd0);
        rst = 0;

        chk("model_100_7", ref_div(0, 32'd100, 32'd7), 64'h00000002_0000000E);
        chk("model_m7_2", ref_div(1, 32'hFFFF_FFF9, 32'd2), 64'hFFFFFFFF_FFFFFFFD);
        chk("model_ovf", ref_div(1, 32'h8000_0000, 32'hFFFF_FFFF), 64'h00000000_80000000);

        run(0, 32'd100, 32'd7, 4, 0, 1, 64'h00000002_0000000E);
        run(1, 32'hFFFF_FFF9, 32'd2, 1, 0, 1, 64'hFFFFFFFF_FFFFFFFD);
        run(1, 32'd7, 32'hFFFF_FFFE, 1, 0, 1, 64'h00000001_FFFFFFFD);
        run(0, 32'd5, 32'd0, 2, 0, 1, 64'd0);
        run(1, 32'd5, 32'd0, 2, 0, 1, 64'd0);
        run(0, 32'hFFFF_FFFF, 32'd1, 0, 0, 1, 64'h00000000_FFFFFFFF);
        run(0, 32'd1000, 32'd3, 0, 10, 0, 64'd0);
        run(0, 32'd9, 32'd3, 0, 0, 1, 64'h00000000_00000003);
        run(1, 32'h8000_0000, 32'hFFFF_FFFF, 2, 0, 1, 64'h00000000_80000000);
        run(0, 32'hFFFF_FFFE, 32'h8000_0001, 0, 0, 1, 64'h7FFFFFFD_00000001);

        // Reset in the middle of a division
        @(negedge clk);
        signed_div = 0; opdata1 = 32'd100; opdata2 = 32'd7; start = 1; annul = 0;
        repeat (21) @(posedge clk);
        #1 rst = 1;
        @(posedge clk); #1;
        chk("midrst_ready", {63'd0, ready}, 64'd0);
        chk("midrst_result", result, 64'd0);
        rst = 0; start = 0;

        // start with annul in IDLE is never accepted
        @(negedge clk); start = 1; annul = 1;
        hi = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (ready) hi++;
        end
        chk("annul_idle", 64'(hi), 64'd0);
        @(negedge clk); start = 0; annul = 0;

        for (int i = 0; i < 150; i++) begin
            run(1'($urandom % 2), pick(), pick(), int'($urandom % 4),
                ($urandom % 8 == 0) ? int'($urandom_range(1, 34)) : 0, 0, 64'd0);
        end

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle radix-2 restoring divider in the execute stage, serving DIV/DIVU.
- Consumes the two register-file read operands and produces a {remainder, quotient} pair that write-back places in HI/LO.
- While busy, the pipeline controller stalls on ready=0.

Parameters:
- WIDTH, 32, operand width in bits; also the iteration count.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- signed_div  in  1  1 = signed division, 0 = unsigned; sampled with start.
- opdata1  in  WIDTH  dividend (register-file read port 1 data).
- opdata2  in  WIDTH  divisor (register-file read port 2 data).
- start  in  1  request; held high by the controller until it has consumed ready.
- annul  in  1  cancel an in-flight division (flush from branch or exception).
- result  out  2*WIDTH  {remainder[2W-1:W], quotient[W-1:0]}; registered.
- ready  out  1  result valid; registered.

Behaviour:
- Reset: state=IDLE, result=0, ready=0, counter=0, all internal registers=0. Reset wins over every other input in any state, including mid-division.
- Operand capture:
  - signed_div, opdata1 and opdata2 are latched on the accepting edge only; later changes are ignored.
  - signed_div=1: magnitudes of negative operands are latched (two's-complement negate). Sign flags s1=opdata1[W-1] and s2=opdata2[W-1] are stored.
  - signed_div=0: s1=s2=0; operands are latched unchanged.
- FSM, four states:
  - IDLE:
    - start=1 and annul=0: if opdata2==0, go to BYZERO; else go to ON with counter=0 and the working register {W'b0, |opdata1|, 1'b0} loaded.
    - Otherwise stay in IDLE. ready=0, result=0.
  - BYZERO:
    - annul=1: go to IDLE.
    - Else go to END with result=0.
  - ON:
    - annul=1: go to IDLE; the partial result is discarded and ready stays 0.
    - counter<WIDTH: one iteration per edge. diff = upper(W+1) bits − {0,divisor}. If diff is non-negative, the upper bits become diff and the shifted-in quotient bit is 1; else the quotient bit is 0. Shift left by one; counter+1.
    - counter==WIDTH: go to END.
      - Quotient is negated iff signed_div && (s1^s2).
      - Remainder is negated iff signed_div && s1.
      - result={rem, quo}; ready=1.
  - END:
    - ready=1 and result hold while start=1. annul is ignored.
    - start=0: go to IDLE; ready=0, result=0 on the same edge.
- Latency:
  - Normal division: ready rises on the WIDTH+2th rising edge after and including the accepting edge. For WIDTH=32 that is the 34th edge.
  - Divide-by-zero: ready rises on the 2nd edge.
- A new start is accepted only in IDLE, so at least one cycle with start=0 must separate back-to-back divisions.
- Arithmetic is performed on magnitudes in W+1-bit unsigned.
- Signed overflow case −2^(W−1) / −1: the quotient is 2^(W−1) unnegated, giving 0x80000000; remainder is 0. No trap.
- Remainder sign follows the dividend; quotient truncates toward zero (MIPS semantics).

Test Plan:
- Unsigned 100/7, signed_div=0, start held: ready=0 for 33 edges, ready=1 on the 34th edge, result=64'h00000002_0000000E; ready and result stay stable while start=1. Dropping start clears ready and result the next edge.
- Signed −7/2 (0xFFFFFFF9 / 0x00000002), signed_div=1: result={32'hFFFFFFFF, 32'hFFFFFFFD}. Also signed 7/−2 → {32'h00000001, 32'hFFFFFFFD}.
- Divide-by-zero 5/0 in both modes: ready=1 on the 2nd edge, result=0. Also unsigned 0xFFFFFFFF/1 → {0, 0xFFFFFFFF}.
- Annul at edge 10 of ON: state returns to IDLE, ready never rises. Then start 9/3 after one idle cycle: result={0, 3} at the 34th edge.
- Signed 0x80000000 / 0xFFFFFFFF → result={32'h0, 32'h80000000}. Changing opdata1/opdata2 during ON does not alter the result.
- rst=1 at edge 20 of ON: next edge ready=0, result=0, state IDLE. start with annul=1 in IDLE is not accepted (ready stays 0 for 40 edges).
